// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch front end. Issues one instruction-memory request at a time
// from a running fetch PC, places each returned word into an output register
// for decode, and absorbs a single response in a one-entry hold buffer while
// decode is stalled. Redirects (branch/jump) replace the fetch PC, flush the
// output and hold buffer, and discard any response still in flight.
//
// Parameters
//   ARCH_LEN  address width
//   INST_LEN  instruction width
//   RESET_PC  first fetch address after reset
//   NOP_INST  bubble driven on inst_fetched_out when inst_valid_out=0
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   stall_in            decode stall; holds a valid output instruction
//   redirect_valid/pc   redirect request and target (low two bits ignored)
//   imem_req_*          request channel (valid/ready handshake, word address)
//   imem_rsp_*          response channel (1-cycle valid pulse, in order)
//   inst_fetched_out    instruction to decode, NOP_INST when not valid
//   inst_valid_out      inst_fetched_out holds a real instruction
//   pc_out              PC of inst_fetched_out
//   perf_fetched        (FETCH_PERF_CNT_EN) responses delivered to decode
//   perf_stall_cycles   (FETCH_PERF_CNT_EN) cycles with a valid output stalled
//
// Build option
//   FETCH_PERF_CNT_EN   adds the two 32-bit performance counter outputs.
// ----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned          ARCH_LEN = 32,
  parameter int unsigned          INST_LEN = 32,
  parameter logic [ARCH_LEN-1:0]  RESET_PC = 32'h0000_1000,
  parameter logic [INST_LEN-1:0]  NOP_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_in,
  input  logic                redirect_valid,
  input  logic [ARCH_LEN-1:0] redirect_pc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ARCH_LEN-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [INST_LEN-1:0] imem_rsp_data,
  output logic [INST_LEN-1:0] inst_fetched_out,
  output logic                inst_valid_out,
  output logic [ARCH_LEN-1:0] pc_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // no request outstanding
    ST_REQ  = 2'd1,   // request presented, waiting for ready
    ST_WAIT = 2'd2    // request accepted, waiting for the response
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [ARCH_LEN-1:0]  r_fetch_pc;
  logic [ARCH_LEN-1:0]  r_req_pc;      // PC of the request in flight
  logic                 r_drop;        // in-flight response belongs to a flushed path

  logic                 r_hold_valid;
  logic [INST_LEN-1:0]  r_hold_inst;
  logic [ARCH_LEN-1:0]  r_hold_pc;

  logic                 r_out_valid;
  logic [INST_LEN-1:0]  r_out_inst;
  logic [ARCH_LEN-1:0]  r_out_pc;

  logic                 w_accept;
  logic                 w_rsp;
  logic                 w_rsp_use;
  logic                 w_out_hold;
  logic                 w_rsp_to_hold;
  logic                 w_rsp_to_out;
  logic [ARCH_LEN-1:0]  w_redirect_target;

  // Masking rather than slicing keeps the whole redirect bus in use.
  assign w_redirect_target = redirect_pc & ~ARCH_LEN'(3);

  assign imem_req_valid = (r_state == ST_REQ) && !rst;
  assign imem_req_addr  = r_fetch_pc;

  assign w_accept      = imem_req_valid && imem_req_ready;
  // Only a response in WAIT answers our request; anything else is stale.
  assign w_rsp         = (r_state == ST_WAIT) && imem_rsp_valid;
  assign w_rsp_use     = w_rsp && !r_drop && !redirect_valid;
  assign w_out_hold    = stall_in && r_out_valid;
  assign w_rsp_to_hold = w_rsp_use && w_out_hold;
  assign w_rsp_to_out  = w_rsp_use && !w_out_hold;

  // ------------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves the
    // output unassigned, which would infer a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        // A redirect empties the hold buffer, so fetching may restart.
        if (redirect_valid || !r_hold_valid) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (w_accept) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_rsp) w_state_nxt = w_rsp_to_hold ? ST_IDLE : ST_REQ;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Fetch PC and drop flag
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_drop     <= 1'b0;
    end else begin
      if (redirect_valid)  r_fetch_pc <= w_redirect_target;
      else if (w_accept)   r_fetch_pc <= r_fetch_pc + ARCH_LEN'(4);

      // A redirect coincident with the response needs no flag: that
      // response is discarded directly.
      if (w_rsp)
        r_drop <= 1'b0;
      else if (redirect_valid && ((r_state == ST_WAIT) || w_accept))
        r_drop <= 1'b1;
    end
  end

  // NOTE: pure datapath registers carry no reset; their contents are only
  // consumed under a valid/state qualifier that is itself reset.
  always_ff @(posedge clk) begin
    if (w_accept)      r_req_pc <= r_fetch_pc;
    if (w_rsp_to_hold) begin
      r_hold_inst <= imem_rsp_data;
      r_hold_pc   <= r_req_pc;
    end
  end

  // ------------------------------------------------------------------------
  // Hold buffer occupancy
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || redirect_valid)            r_hold_valid <= 1'b0;
    else if (w_rsp_to_hold)               r_hold_valid <= 1'b1;
    else if (!w_out_hold && r_hold_valid) r_hold_valid <= 1'b0;
  end

  // ------------------------------------------------------------------------
  // Output register: redirect > stall > hold buffer > new response > bubble
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_inst  <= NOP_INST;
      r_out_pc    <= '0;
    end else if (redirect_valid) begin
      r_out_valid <= 1'b0;
      r_out_inst  <= NOP_INST;
    end else if (w_out_hold) begin
      r_out_valid <= r_out_valid;
    end else if (r_hold_valid) begin
      r_out_valid <= 1'b1;
      r_out_inst  <= r_hold_inst;
      r_out_pc    <= r_hold_pc;
    end else if (w_rsp_to_out) begin
      r_out_valid <= 1'b1;
      r_out_inst  <= imem_rsp_data;
      r_out_pc    <= r_req_pc;
    end else begin
      r_out_valid <= 1'b0;
      r_out_inst  <= NOP_INST;
    end
  end

  assign inst_fetched_out = r_out_inst;
  assign inst_valid_out   = r_out_valid;
  assign pc_out           = r_out_pc;

`ifdef FETCH_PERF_CNT_EN
  // ------------------------------------------------------------------------
  // Performance counters (free-running, wrap at 2^32)
  // ------------------------------------------------------------------------
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;
  logic        w_deliver;

  // Mirrors the output-register load conditions for a real instruction.
  assign w_deliver = !redirect_valid && !w_out_hold && (r_hold_valid || w_rsp_to_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_deliver)  r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_out_hold) r_perf_stall   <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched      = r_perf_fetched;
  assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_1000, is the first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (ADDI x0,x0,0), is the bubble driven when no valid instruction is present.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 stall_in  input  1  decode stall; when 1, the output instruction is held unchanged.
REQ-006 redirect_valid  input  1  branch/jump redirect request.
REQ-007 redirect_pc  input  ARCH_LEN  redirect target.
REQ-008 imem_req_valid  output  1  instruction-memory request valid.
REQ-009 imem_req_ready  input  1  instruction memory accepts the request.
REQ-010 imem_req_addr  output  ARCH_LEN  request address, word aligned.
REQ-011 imem_rsp_valid  input  1  response valid, 1-cycle pulse, in order.
REQ-012 imem_rsp_data  input  INST_LEN  fetched instruction word.
REQ-013 inst_fetched_out  output  INST_LEN  instruction to decode; NOP_INST when not valid.
REQ-014 inst_valid_out  output  1  inst_fetched_out holds a real instruction.
REQ-015 pc_out  output  ARCH_LEN  PC of inst_fetched_out.

Function
REQ-016 FSM states: IDLE (no request outstanding), REQ (imem_req_valid=1, awaiting ready), WAIT (request accepted, awaiting response).
REQ-017 IDLE->REQ unconditionally when the hold buffer is empty; REQ->WAIT on imem_req_valid & imem_req_ready; WAIT->REQ on the response when the response is consumed into the output register; WAIT->IDLE on the response when it is placed in the hold buffer.
REQ-018 At most one request is outstanding; imem_req_addr equals fetch_pc and stays stable while in REQ.
REQ-019 A response seen in cycle N appears on inst_fetched_out/pc_out with inst_valid_out=1 in cycle N+1 when stall_in=0 or inst_valid_out=0.
REQ-020 A response arriving while stall_in=1 and inst_valid_out=1 goes into a 1-entry hold buffer; no new request issues while the buffer is full.
REQ-021 When stall_in falls, the hold buffer moves to the output register on the next edge and the FSM then returns to REQ.
REQ-022 With stall_in=0, the output register advances each cycle: next instruction, or NOP_INST with valid 0 if none is available.
REQ-023 fetch_pc increments by 4 when each request is accepted; 32'hFFFF_FFFC+4 wraps to 0.
REQ-024 Redirect has highest priority, including over stall_in, and takes effect on the next edge:
  - fetch_pc <= {redirect_pc[ARCH_LEN-1:2],2'b00}
  - output becomes NOP_INST with valid 0
  - hold buffer is cleared
REQ-025 Redirect while in REQ without ready: the request is withdrawn and a new request to the target issues the next cycle.
REQ-026 Redirect while in WAIT, or in the same cycle as acceptance: a drop flag is set, the matching response is discarded, and the request to the target issues the cycle after that response.
REQ-027 A response coincident with a redirect is discarded.

Reset
REQ-028 While rst=1:
  - state=IDLE, fetch_pc=RESET_PC, hold buffer empty, drop flag=0
  - imem_req_valid=0, inst_valid_out=0, inst_fetched_out=NOP_INST, pc_out=0
REQ-029 rst asserted mid-transaction drops any outstanding response; the first request after reset is RESET_PC, issued the cycle after rst falls.

Configuration
REQ-030 With FETCH_PERF_CNT_EN defined, the block adds two 32-bit outputs:
  - perf_fetched: increments on each response delivered to the output register
  - perf_stall_cycles: increments on each cycle with stall_in=1 and inst_valid_out=1
  - both reset to 0 and wrap at 2^32
REQ-031 Without FETCH_PERF_CNT_EN, these ports and counters are absent and all other behaviour is identical.

Verification
REQ-032 Reset release, memory with ready=1 and 1-cycle latency -> requests to 0x1000, 0x1004, 0x1008; the output shows each word with pc_out matching and valid=1.
REQ-033 stall_in=1 for 3 cycles while the instruction at 0x1004 is on the output -> output is held, the 0x1008 response goes to the hold buffer, no request for 0x100C; after release, 0x1008 is output the next cycle.
REQ-034 Redirect to 0x2002 while in WAIT for 0x1010 -> the 0x1010 response is discarded, output is NOP_INST/valid 0, and the next request is 0x2000.
REQ-035 fetch_pc=0xFFFF_FFFC accepted -> the next request address is 0x0000_0000.
REQ-036 rst pulsed 1 cycle while in WAIT; the response arrives after reset -> it is ignored, and the first request is 0x1000.
REQ-037 FETCH_PERF_CNT_EN build: 5 instructions delivered with 2 stall cycles -> perf_fetched=5, perf_stall_cycles=2.
